// File: rtl/param_regfile.sv
// rtl/param_regfile.sv - parameterised 2R1W register file with self-clearing FSM and registered reads.
// Optional REGFILE_BYPASS_EN forwards a same-cycle accepted write to a matching read port.
module param_regfile #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [AW-1:0]    r1_addr,
  input  logic [AW-1:0]    r2_addr,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             wr_drop
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

  state_t            state, state_nx;
  logic [AW-1:0]     ptr, ptr_nx;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic              drop_nx;
  logic [WIDTH-1:0]  rd1_nx, rd2_nx;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A read port returns stored data only when the file is usable and the address is backed.
  function automatic logic rd_ok(input state_t st, input logic [AW-1:0] a);
    return (st == READY) && in_range(a) && !is_zero_reg(a);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      CLEAR: begin
        ptr_nx = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_nx = READY;
          ptr_nx   = '0;
        end
      end
      READY: begin
        if (clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        ptr_nx   = '0;
      end
    endcase
  end

  // Writes to the hard-wired zero register vanish silently; only CLEAR or a bad address flag a drop.
  always_comb begin
    wr_ok   = (state == READY) && wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
    drop_nx = wr_en && ((state == CLEAR) || !in_range(wr_addr));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[ptr] <= '0;
      else if (wr_ok)
        mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1_nx = '0;
    rd2_nx = '0;
    if (rd_ok(state, r1_addr))
      rd1_nx = mem[r1_addr];
    if (rd_ok(state, r2_addr))
      rd2_nx = mem[r2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (wr_addr == r1_addr))
      rd1_nx = wr_data;
    if (wr_ok && (wr_addr == r2_addr))
      rd2_nx = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd1     <= '0;
      rd2     <= '0;
      wr_drop <= 1'b0;
    end else begin
      rd1     <= rd1_nx;
      rd2     <= rd2_nx;
      wr_drop <= drop_nx;
    end
  end

  assign busy = (state == CLEAR);

endmodule

// File: tb/tb_param_regfile.sv
// tb/tb_param_regfile.sv - bench for param_regfile: DEPTH=32 and DEPTH=20 instances against a model.
module tb_param_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        clr  [2];
  logic        wen  [2];
  logic [4:0]  ra1  [2];
  logic [4:0]  ra2  [2];
  logic [4:0]  wa   [2];
  logic [31:0] wd   [2];
  logic [31:0] rd1  [2];
  logic [31:0] rd2  [2];
  logic        busy [2];
  logic        drop [2];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  param_regfile u32 (
    .clk(clk), .reset(rst[0]), .clr(clr[0]), .r1_addr(ra1[0]), .r2_addr(ra2[0]),
    .rd1(rd1[0]), .rd2(rd2[0]), .wr_en(wen[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
    .busy(busy[0]), .wr_drop(drop[0])
  );

  param_regfile #(.DEPTH(20)) u20 (
    .clk(clk), .reset(rst[1]), .clr(clr[1]), .r1_addr(ra1[1]), .r2_addr(ra2[1]),
    .rd1(rd1[1]), .rd2(rd2[1]), .wr_en(wen[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
    .busy(busy[1]), .wr_drop(drop[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: clear_left counts remaining busy cycles; the array is zeroed when a clear completes.
  int          dep [2] = '{32, 20};
  logic [31:0] mm  [2][32];
  int          clear_left [2] = '{0, 0};
  logic [31:0] e1 [2];
  logic [31:0] e2 [2];
  logic        ed [2];
  bit          started [2] = '{1'b0, 1'b0};

  function automatic logic [31:0] model_read(int i, int a, bit clearing, bit acc);
    if (clearing || a >= dep[i] || a == 0) return 32'd0;
    if (BYP && acc && int'(wa[i]) == a) return wd[i];
    return mm[i][a];
  endfunction

  always @(posedge clk) begin : model
    bit clearing;
    bit acc;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        clear_left[i] = dep[i];
        e1[i] = 32'd0;
        e2[i] = 32'd0;
        ed[i] = 1'b0;
        started[i] = 1'b1;
      end else begin
        clearing = clear_left[i] > 0;
        acc = !clearing && wen[i] && int'(wa[i]) < dep[i] && wa[i] != 5'd0;
        e1[i] = model_read(i, int'(ra1[i]), clearing, acc);
        e2[i] = model_read(i, int'(ra2[i]), clearing, acc);
        ed[i] = wen[i] && (clearing || int'(wa[i]) >= dep[i]);
        if (acc) mm[i][wa[i]] = wd[i];
        if (clearing) begin
          clear_left[i]--;
          if (clear_left[i] == 0)
            for (int j = 0; j < 32; j++) mm[i][j] = 32'd0;
        end else if (clr[i]) begin
          clear_left[i] = dep[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (started[i]) begin
        check($sformatf("model_busy[%0d]", i), 32'(busy[i]), 32'(clear_left[i] > 0));
        check($sformatf("model_rd1[%0d]", i), rd1[i], e1[i]);
        check($sformatf("model_rd2[%0d]", i), rd2[i], e2[i]);
        check($sformatf("model_drop[%0d]", i), 32'(drop[i]), 32'(ed[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int i, output int n);
    n = 0;
    while (busy[i] && n < 3000) begin
      n++;
      step();
    end
  endtask

  task automatic wr(input int i, input int a, input int d);
    wen[i] = 1'b1;
    wa[i]  = 5'(a);
    wd[i]  = 32'(d);
    step();
    wen[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; clr[i] = 1'b0; wen[i] = 1'b0;
      ra1[i] = '0; ra2[i] = '0; wa[i] = '0; wd[i] = '0;
    end
    step();
    check("reset_rd1", rd1[0], 32'd0);
    check("reset_drop", 32'(drop[0]), 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    count_busy(0, n);
    check("busy_len_32", n, 32);

    ra1[0] = 5'd15; ra2[0] = 5'd7;
    step();
    check("cleared_r15", rd1[0], 32'd0);
    check("cleared_r7", rd2[0], 32'd0);

    wr(0, 15, 120);
    wr(0, 17, 2);
    wr(0, 7, 3);
    ra1[0] = 5'd15; ra2[0] = 5'd7;
    step();
    check("read_r15", rd1[0], 32'd120);
    check("read_r7", rd2[0], 32'd3);
    ra1[0] = 5'd17; ra2[0] = 5'd17;
    step();
    check("same_addr_p1", rd1[0], 32'd2);
    check("same_addr_p2", rd2[0], 32'd2);

    ra1[0] = 5'd20;
    wr(0, 20, 132);
    check("bypass_same_cycle", rd1[0], BYP ? 32'd132 : 32'd0);
    step();
    check("after_write_r20", rd1[0], 32'd132);

    ra1[0] = 5'd0;
    wr(0, 0, 55);
    check("zero_reg_read", rd1[0], 32'd0);
    check("zero_reg_nodrop", 32'(drop[0]), 32'd0);
    step();
    check("zero_reg_after", rd1[0], 32'd0);

    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("clr_busy", 32'(busy[0]), 32'd1);
    wr(0, 15, 72);
    check("drop_in_clear", 32'(drop[0]), 32'd1);
    step();
    check("drop_one_cycle", 32'(drop[0]), 32'd0);
    count_busy(0, n);
    check("clr_busy_rest", n, 30);
    ra1[0] = 5'd15; ra2[0] = 5'd17;
    step();
    check("after_clr_r15", rd1[0], 32'd0);
    check("after_clr_r17", rd2[0], 32'd0);

    wr(0, 9, 44);
    rst[0] = 1'b1;
    wr(0, 9, 99);
    rst[0] = 1'b0;
    check("reset_write_drop", 32'(drop[0]), 32'd0);
    count_busy(0, n);
    check("busy_len_32_again", n, 32);
    ra1[0] = 5'd9;
    step();
    check("after_reset_r9", rd1[0], 32'd0);

    wr(1, 25, 9);
    check("d20_drop_25", 32'(drop[1]), 32'd1);
    ra1[1] = 5'd25;
    step();
    check("d20_read_25", rd1[1], 32'd0);
    wr(1, 20, 5);
    check("d20_drop_20", 32'(drop[1]), 32'd1);
    wr(1, 19, 77);
    check("d20_nodrop_19", 32'(drop[1]), 32'd0);
    ra1[1] = 5'd19; ra2[1] = 5'd20;
    step();
    check("d20_read_19", rd1[1], 32'd77);
    check("d20_read_20", rd2[1], 32'd0);

    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    count_busy(1, n);
    check("d20_busy_after_reset", n, 20);
    step();
    check("d20_cleared_19", rd1[1], 32'd0);

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, number of registers, legal range 2..1024.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-004 The block SHALL derive AW = $clog2(DEPTH) as the address width.
REQ-005 One clock, clk; reset is synchronous and active-high, named reset.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous active-high reset.
- clr  in  1  request to re-clear the whole file.
- r1_addr  in  AW  read port 1 address.
- r2_addr  in  AW  read port 2 address.
- rd1  out  WIDTH  read port 1 data, registered.
- rd2  out  WIDTH  read port 2 data, registered.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- busy  out  1  high while the file is clearing.
- wr_drop  out  1  one-cycle pulse when an asserted write is discarded.

Function
REQ-007 The FSM SHALL have two states: CLEAR and READY.
REQ-008 In CLEAR, each cycle SHALL write 0 to mem[ptr] and increment ptr; after ptr = DEPTH-1 is written, the next state SHALL be READY.
REQ-009 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-010 clr = 1 in READY SHALL enter CLEAR with ptr = 0 on the next edge; clr in CLEAR SHALL be ignored.
REQ-011 In READY, wr_en = 1 with wr_addr < DEPTH SHALL write wr_data to mem[wr_addr] on that edge.
REQ-012 A write to address 0 with ZERO_REG = 1 SHALL be discarded without pulsing wr_drop.
REQ-013 wr_drop SHALL pulse for one cycle when wr_en = 1 and the write is discarded for either reason: state is CLEAR, or wr_addr >= DEPTH.
REQ-014 Reads SHALL have one-cycle latency: rdN after edge k equals mem[rN_addr] sampled at edge k.
REQ-015 rdN SHALL be 0 when rN_addr >= DEPTH, when rN_addr = 0 with ZERO_REG = 1, or when the state at the sampling edge is CLEAR.
REQ-016 Both read ports SHALL be fully independent; equal addresses SHALL return equal data.
REQ-017 A write in cycle k SHALL be visible to a read sampled at edge k+1 or later in all configurations.

Reset
REQ-018 reset = 1 at an edge SHALL set state = CLEAR, ptr = 0, rd1 = 0, rd2 = 0, wr_drop = 0.
REQ-019 After reset, busy SHALL stay 1 for exactly DEPTH cycles, counted from the first edge with reset = 0.
REQ-020 reset asserted mid-clear or mid-write SHALL restart the clear from ptr = 0; a write in the same cycle as reset SHALL be discarded.
REQ-021 Memory contents SHALL NOT be assumed zero until the first clear completes.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
- Defined: a read sampled in the same cycle as an accepted write to the same address SHALL return wr_data.
- Undefined: that read SHALL return the old stored value.

Verification
REQ-023 Reset for 1 cycle, then idle -> busy = 1 for exactly 32 cycles, then 0; reads of r1 = 15, r2 = 7 return 0, 0.
REQ-024 Write 120 to 15, 2 to 17, and 3 to 7 in READY; then set r1 = 15, r2 = 7 -> next cycle rd1 = 120, rd2 = 3.
REQ-025 Write 132 to 20 and read r1 = 20 in the same cycle -> rd1 = 132 with REGFILE_BYPASS_EN, 0 without; the following cycle rd1 = 132 in both.
REQ-026 Write 55 to 0 with ZERO_REG = 1 -> rd1 of address 0 = 0 and wr_drop = 0.
REQ-027 Pulse clr in READY, then write 72 to 15 during CLEAR -> wr_drop pulses; after busy falls, address 15 reads 0.
REQ-028 DEPTH = 20: write 9 to 25 -> wr_drop pulses and reading address 25 returns 0; assert reset at clear cycle 10 -> busy lasts 20 more cycles.
